ram_sp_bwe_fault: RTL and testbench

Parametrised single-port synchronous SRAM model, used as the memory-under-test behind mem_interface in MBIST netlists. Next generation of the plain single-port RAM model, adding:
- honoured odd/even bit-write enables
- output enable
- configurable read latency with a valid flag
- a runtime-programmable stuck-at fault table, so pmbist march algorithms can be proven to detect faults.

---
 rtl/ram_sp_bwe_fault_if.sv | 39 +++
 rtl/ram_sp_bwe_fault.sv | 120 ++++++++++++
 tb/tb_ram_sp_bwe_fault.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_sp_bwe_fault_if.sv
// Bus bundle for the single-port fault-injecting SRAM model: access port,
// fault-table programming port and read-return signals.
interface ram_sp_bwe_fault_if #(
   parameter int DATA_WIDTH = 7,
   parameter int ADDR_WIDTH = 4,
   parameter int FAULT_NUM  = 2
);
   localparam int FB_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int FI_W = (FAULT_NUM > 1) ? $clog2(FAULT_NUM) : 1;

   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data;
   logic                  cs;
   logic                  we;
   logic                  oe;
   logic                  odd_bwe;
   logic                  even_bwe;
   logic [DATA_WIDTH-1:0] data_output;
   logic                  rd_valid;
   logic                  fault_hit;
   logic                  fault_wr;
   logic [FI_W-1:0]       fault_idx;
   logic                  fault_en;
   logic [ADDR_WIDTH-1:0] fault_addr;
   logic [FB_W-1:0]       fault_bit;
   logic                  fault_val;

   modport master (
      output address, data, cs, we, oe, odd_bwe, even_bwe,
      output fault_wr, fault_idx, fault_en, fault_addr, fault_bit, fault_val,
      input  data_output, rd_valid, fault_hit
   );

   modport slave (
      input  address, data, cs, we, oe, odd_bwe, even_bwe,
      input  fault_wr, fault_idx, fault_en, fault_addr, fault_bit, fault_val,
      output data_output, rd_valid, fault_hit
   );
endinterface

// File: rtl/ram_sp_bwe_fault.sv
// Single-port SRAM model with odd/even bit-write enables, output enable,
// RD_LAT-deep read pipeline and a programmable stuck-at fault table.
module ram_sp_bwe_fault #(
   parameter int DATA_WIDTH = 7,
   parameter int ADDR_WIDTH = 4,
   parameter int RD_LAT     = 1,
   parameter int FAULT_NUM  = 2
) (
   input  logic              clk,
   input  logic              rstn,
   ram_sp_bwe_fault_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int FB_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int FI_W  = (FAULT_NUM > 1) ? $clog2(FAULT_NUM) : 1;

   generate
      if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
         $error("ram_sp_bwe_fault: RD_LAT must be within 1..3");
      end
      if (FAULT_NUM < 1 || FAULT_NUM > 8) begin : g_bad_fault_num
         $error("ram_sp_bwe_fault: FAULT_NUM must be within 1..8");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] wr_mask;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
         assign wr_mask[gi] = (gi % 2 == 1) ? bus.odd_bwe : bus.even_bwe;
      end
   endgenerate

   // Array is deliberately outside the reset domain so contents survive rstn.
   always_ff @(posedge clk) begin
      if (bus.cs && bus.we) begin
         mem_q[bus.address] <= (mem_q[bus.address] & ~wr_mask) | (bus.data & wr_mask);
      end
   end

   logic                  fault_en_q   [FAULT_NUM];
   logic [ADDR_WIDTH-1:0] fault_addr_q [FAULT_NUM];
   logic [FB_W-1:0]       fault_bit_q  [FAULT_NUM];
   logic                  fault_val_q  [FAULT_NUM];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int e = 0; e < FAULT_NUM; e++) begin
            fault_en_q[e]   <= 1'b0;
            fault_addr_q[e] <= '0;
            fault_bit_q[e]  <= '0;
            fault_val_q[e]  <= 1'b0;
         end
      end else if (bus.fault_wr) begin
         for (int e = 0; e < FAULT_NUM; e++) begin
            if (bus.fault_idx == FI_W'(e)) begin
               fault_en_q[e]   <= bus.fault_en;
               fault_addr_q[e] <= bus.fault_addr;
               fault_bit_q[e]  <= bus.fault_bit;
               fault_val_q[e]  <= bus.fault_val;
            end
         end
      end
   end

   logic [DATA_WIDTH-1:0] raw_word;
   logic [DATA_WIDTH-1:0] rd_word_d;
   logic                  rd_hit_d;
   logic                  rd_issue;

   assign rd_issue = bus.cs & ~bus.we;

   // Ascending scan lets the highest matching entry override lower ones;
   // a hit is reported only when the final forced word differs from storage.
   always_comb begin
      raw_word  = mem_q[bus.address];
      rd_word_d = raw_word;
      for (int e = 0; e < FAULT_NUM; e++) begin
         if (fault_en_q[e] && (fault_addr_q[e] == bus.address) &&
             (int'(fault_bit_q[e]) < DATA_WIDTH)) begin
            rd_word_d[fault_bit_q[e]] = fault_val_q[e];
         end
      end
      rd_hit_d = |(rd_word_d ^ raw_word);
   end

   logic [DATA_WIDTH-1:0] stg_data_q [RD_LAT];
   logic                  stg_hit_q  [RD_LAT];
   logic                  stg_vld_q  [RD_LAT];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < RD_LAT; s++) begin
            stg_vld_q[s]  <= 1'b0;
            stg_data_q[s] <= '0;
            stg_hit_q[s]  <= 1'b0;
         end
      end else begin
         stg_vld_q[0] <= rd_issue;
         if (rd_issue) begin
            stg_data_q[0] <= rd_word_d;
            stg_hit_q[0]  <= rd_hit_d;
         end
         for (int s = 1; s < RD_LAT; s++) begin
            stg_vld_q[s] <= stg_vld_q[s-1];
            if (stg_vld_q[s-1]) begin
               stg_data_q[s] <= stg_data_q[s-1];
               stg_hit_q[s]  <= stg_hit_q[s-1];
            end
         end
      end
   end

   // Last stage is the output register; it holds the previous word between reads.
   assign bus.data_output = bus.oe ? stg_data_q[RD_LAT-1] : '0;
   assign bus.rd_valid    = stg_vld_q[RD_LAT-1];
   assign bus.fault_hit   = stg_vld_q[RD_LAT-1] & stg_hit_q[RD_LAT-1];
endmodule

// File: tb/tb_ram_sp_bwe_fault.sv
// Directed bench: RD_LAT=1 instance driven from a vector table, RD_LAT=3
// instance used for latency, fault-index range and mid-read reset sequences.
module tb_ram_sp_bwe_fault;
   logic clk;
   logic rstn;

   ram_sp_bwe_fault_if #(.DATA_WIDTH(7), .ADDR_WIDTH(4), .FAULT_NUM(2)) ifa ();
   ram_sp_bwe_fault_if #(.DATA_WIDTH(7), .ADDR_WIDTH(4), .FAULT_NUM(3)) ifb ();

   ram_sp_bwe_fault #(.DATA_WIDTH(7), .ADDR_WIDTH(4), .RD_LAT(1), .FAULT_NUM(2)) dut_a (
      .clk (clk),
      .rstn(rstn),
      .bus (ifa)
   );

   ram_sp_bwe_fault #(.DATA_WIDTH(7), .ADDR_WIDTH(4), .RD_LAT(3), .FAULT_NUM(3)) dut_b (
      .clk (clk),
      .rstn(rstn),
      .bus (ifb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       cs, we, oe, odd, even;
      logic [3:0] addr;
      logic [6:0] data;
      logic       fwr;
      logic [1:0] fidx;
      logic       fen;
      logic [3:0] faddr;
      logic [2:0] fbit;
      logic       fval;
      logic       exp_vld;
      logic [6:0] exp_data;
      logic       exp_hit;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t tbl[$];

   function automatic vec_t mk(input int cs, input int we, input int oe, input int odd,
                               input int even, input int addr, input int data,
                               input int fwr, input int fidx, input int fen, input int faddr,
                               input int fbit, input int fval,
                               input int ev, input int ed, input int eh);
      vec_t v;
      v.cs = cs[0]; v.we = we[0]; v.oe = oe[0]; v.odd = odd[0]; v.even = even[0];
      v.addr = addr[3:0]; v.data = data[6:0];
      v.fwr = fwr[0]; v.fidx = fidx[1:0]; v.fen = fen[0]; v.faddr = faddr[3:0];
      v.fbit = fbit[2:0]; v.fval = fval[0];
      v.exp_vld = ev[0]; v.exp_data = ed[6:0]; v.exp_hit = eh[0];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_a(input vec_t v);
      ifa.cs = v.cs; ifa.we = v.we; ifa.oe = v.oe; ifa.odd_bwe = v.odd; ifa.even_bwe = v.even;
      ifa.address = v.addr; ifa.data = v.data;
      ifa.fault_wr = v.fwr; ifa.fault_idx = v.fidx[0]; ifa.fault_en = v.fen;
      ifa.fault_addr = v.faddr; ifa.fault_bit = v.fbit; ifa.fault_val = v.fval;
   endtask

   task automatic drive_b(input vec_t v);
      ifb.cs = v.cs; ifb.we = v.we; ifb.oe = v.oe; ifb.odd_bwe = v.odd; ifb.even_bwe = v.even;
      ifb.address = v.addr; ifb.data = v.data;
      ifb.fault_wr = v.fwr; ifb.fault_idx = v.fidx; ifb.fault_en = v.fen;
      ifb.fault_addr = v.faddr; ifb.fault_bit = v.fbit; ifb.fault_val = v.fval;
   endtask

   // RD_LAT=3: read issued now is visible at the third following negedge.
   task automatic b_read_check(input string nm, input int addr, input int ed, input int eh);
      drive_b(mk(1,0,1,0,0,addr,0, 0,0,0,0,0,0, 0,0,0));
      @(negedge clk);
      drive_b(mk(0,0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0));
      @(negedge clk);
      @(negedge clk);
      chk({nm, " vld"},  32'(ifb.rd_valid), 32'd1);
      chk({nm, " data"}, 32'(ifb.data_output), 32'(ed));
      chk({nm, " hit"},  32'(ifb.fault_hit), 32'(eh));
      $display("b read %s addr=%0d data=%0h hit=%0b", nm, addr, ifb.data_output, ifb.fault_hit);
   endtask

   task automatic a_read_check(input string nm, input int addr, input int ed, input int eh);
      drive_a(mk(1,0,1,0,0,addr,0, 0,0,0,0,0,0, 0,0,0));
      @(negedge clk);
      chk({nm, " vld"},  32'(ifa.rd_valid), 32'd1);
      chk({nm, " data"}, 32'(ifa.data_output), 32'(ed));
      chk({nm, " hit"},  32'(ifa.fault_hit), 32'(eh));
      $display("a read %s addr=%0d data=%0h hit=%0b", nm, addr, ifa.data_output, ifa.fault_hit);
      drive_a(mk(0,0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0));
   endtask

   task automatic lat_run(input int oe);
      for (int k = 0; k <= 6; k++) begin
         if (k > 0) begin
            chk($sformatf("lat oe=%0d k=%0d vld", oe, k), 32'(ifb.rd_valid),
                (k >= 3 && k <= 5) ? 32'd1 : 32'd0);
            if (k >= 3 && k <= 5) begin
               chk($sformatf("lat oe=%0d k=%0d data", oe, k), 32'(ifb.data_output),
                   (oe != 0) ? 32'(k - 2) : 32'd0);
               chk($sformatf("lat oe=%0d k=%0d hit", oe, k), 32'(ifb.fault_hit), 32'd0);
            end
            $display("lat oe=%0d k=%0d vld=%0b data=%0h", oe, k, ifb.rd_valid, ifb.data_output);
         end
         if (k < 3) drive_b(mk(1,0,oe,0,0,k,0, 0,0,0,0,0,0, 0,0,0));
         else       drive_b(mk(0,0,oe,0,0,0,0, 0,0,0,0,0,0, 0,0,0));
         @(negedge clk);
      end
   endtask

   initial begin
      rstn = 1'b0;
      drive_a(mk(0,0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0));
      drive_b(mk(0,0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0));

      //      cs we oe od ev ad data   fw fi fe fa fb fv   ev  edata eh
      tbl.push_back(mk(1,1,1,1,1,3,'h55, 0,0,0,0,0,0, 0,'h00,0));
      tbl.push_back(mk(1,0,1,0,0,3,0,    0,0,0,0,0,0, 1,'h55,0));
      tbl.push_back(mk(0,0,1,0,0,0,0,    0,0,0,0,0,0, 0,'h55,0));
      tbl.push_back(mk(1,1,1,1,1,5,'h00, 0,0,0,0,0,0, 0,'h55,0));
      tbl.push_back(mk(1,1,1,1,0,5,'h7F, 0,0,0,0,0,0, 0,'h55,0));
      tbl.push_back(mk(1,0,1,0,0,5,0,    0,0,0,0,0,0, 1,'h2A,0));
      tbl.push_back(mk(1,1,1,0,1,5,'h7F, 0,0,0,0,0,0, 0,'h2A,0));
      tbl.push_back(mk(1,0,1,0,0,5,0,    0,0,0,0,0,0, 1,'h7F,0));
      tbl.push_back(mk(1,1,1,1,1,4,'h33, 0,0,0,0,0,0, 0,'h7F,0));
      tbl.push_back(mk(1,0,1,0,0,5,0,    1,0,1,5,0,0, 1,'h7F,0));
      tbl.push_back(mk(1,0,1,0,0,5,0,    0,0,0,0,0,0, 1,'h7E,1));
      tbl.push_back(mk(1,0,1,0,0,4,0,    0,0,0,0,0,0, 1,'h33,0));
      tbl.push_back(mk(0,0,1,0,0,0,0,    1,1,1,5,0,1, 0,'h33,0));
      tbl.push_back(mk(1,0,1,0,0,5,0,    0,0,0,0,0,0, 1,'h7F,0));
      tbl.push_back(mk(0,0,1,0,0,0,0,    1,1,1,4,7,0, 0,'h7F,0));
      tbl.push_back(mk(1,0,1,0,0,4,0,    0,0,0,0,0,0, 1,'h33,0));
      tbl.push_back(mk(1,0,1,0,0,5,0,    0,0,0,0,0,0, 1,'h7E,1));
      tbl.push_back(mk(1,0,0,0,0,5,0,    0,0,0,0,0,0, 1,'h00,1));
      tbl.push_back(mk(0,0,1,0,0,0,0,    1,1,1,4,6,1, 0,'h7E,0));
      tbl.push_back(mk(1,0,1,0,0,4,0,    0,0,0,0,0,0, 1,'h73,1));
      tbl.push_back(mk(0,0,1,0,0,0,0,    1,0,0,5,0,0, 0,'h73,0));
      tbl.push_back(mk(1,0,1,0,0,5,0,    0,0,0,0,0,0, 1,'h7F,0));
      tbl.push_back(mk(1,1,1,0,0,4,'h00, 0,0,0,0,0,0, 0,'h7F,0));
      tbl.push_back(mk(1,0,1,0,0,4,0,    0,0,0,0,0,0, 1,'h73,1));

      repeat (2) @(negedge clk);
      chk("reset a data", 32'(ifa.data_output), 32'd0);
      chk("reset a vld",  32'(ifa.rd_valid), 32'd0);
      chk("reset a hit",  32'(ifa.fault_hit), 32'd0);
      chk("reset b data", 32'(ifb.data_output), 32'd0);
      chk("reset b vld",  32'(ifb.rd_valid), 32'd0);
      chk("reset b hit",  32'(ifb.fault_hit), 32'd0);
      rstn = 1'b1;

      foreach (tbl[i]) begin
         drive_a(tbl[i]);
         @(negedge clk);
         chk($sformatf("vec%0d vld", i),  32'(ifa.rd_valid), 32'(tbl[i].exp_vld));
         chk($sformatf("vec%0d data", i), 32'(ifa.data_output), 32'(tbl[i].exp_data));
         chk($sformatf("vec%0d hit", i),  32'(ifa.fault_hit), 32'(tbl[i].exp_hit));
         $display("vec%0d cs=%0b we=%0b addr=%0d fwr=%0b -> vld=%0b data=%0h hit=%0b",
                  i, tbl[i].cs, tbl[i].we, tbl[i].addr, tbl[i].fwr,
                  ifa.rd_valid, ifa.data_output, ifa.fault_hit);
      end
      drive_a(mk(0,0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0));

      for (int a = 0; a < 3; a++) begin
         drive_b(mk(1,1,1,1,1,a,a+1, 0,0,0,0,0,0, 0,0,0));
         @(negedge clk);
      end
      drive_b(mk(0,0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0));
      @(negedge clk);
      lat_run(1);
      lat_run(0);

      // Index 3 is beyond a 3-entry table and must be dropped.
      drive_b(mk(0,0,1,0,0,0,0, 1,3,1,0,0,0, 0,0,0));
      @(negedge clk);
      b_read_check("idx oob", 0, 'h01, 0);
      drive_b(mk(0,0,1,0,0,0,0, 1,2,1,0,0,0, 0,0,0));
      @(negedge clk);
      b_read_check("idx2", 0, 'h00, 1);

      drive_b(mk(1,0,1,0,0,1,0, 0,0,0,0,0,0, 0,0,0));
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("midrst b vld",  32'(ifb.rd_valid), 32'd0);
      chk("midrst b data", 32'(ifb.data_output), 32'd0);
      chk("midrst b hit",  32'(ifb.fault_hit), 32'd0);
      chk("midrst a data", 32'(ifa.data_output), 32'd0);
      drive_b(mk(0,0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0));
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("post rst vld k=%0d", k), 32'(ifb.rd_valid), 32'd0);
      end
      a_read_check("after rst a4", 4, 'h33, 0);
      b_read_check("after rst b1", 1, 'h02, 0);
      b_read_check("after rst b0", 0, 'h01, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
